// File: rtl/lavagem_pkg.sv
// Shared types for the washing-machine program controller: state codes and
// the rinse-count width.
package lavagem_pkg;

    localparam int unsigned EST_W = 3;
    localparam int unsigned NE_W  = 2;

    typedef enum logic [EST_W-1:0] {
        ESPERA      = 3'd0,
        ENCHER      = 3'd1,
        AGITAR      = 3'd2,
        MOLHO       = 3'd3,
        ESVAZIAR    = 3'd4,
        CENTRIFUGAR = 3'd5,
        INVALIDO    = 3'd6,
        ERRO        = 3'd7
    } estado_t;

    // True for the program phases (1..5), where pause and the timer apply.
    function automatic logic em_fase(input estado_t s);
        return (s >= ENCHER) && (s <= CENTRIFUGAR);
    endfunction

endpackage

// File: rtl/temporizador_fase.sv
// Phase timer: counts enabled cycles since the last clear and flags the
// cycle in which the count equals limite-1.
module temporizador_fase #(
    parameter int unsigned TW = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          limpar,
    input  logic          habilitar,
    input  logic [TW-1:0] limite,
    output logic          terminal_c
);

    logic [TW-1:0] contagem;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            contagem <= '0;
        end else if (limpar) begin
            contagem <= '0;
        end else if (habilitar) begin
            contagem <= contagem + TW'(1);
        end
    end

    assign terminal_c = (contagem == (limite - TW'(1)));

endmodule

// File: rtl/controlador_lavagem.sv
// Washing-machine program sequencer: fill, agitate, soak, drain, rinse passes
// and optional spin, with pause, sensor timeouts and an error state.
module controlador_lavagem
    import lavagem_pkg::*;
#(
    parameter int unsigned TW            = 16,
    parameter int unsigned T_AGITAR      = 1000,
    parameter int unsigned T_MOLHO       = 500,
    parameter int unsigned T_CENTRIFUGAR = 800,
    parameter int unsigned T_LIMITE      = 2000
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            inicio,
    input  logic            pausa,
    input  logic            cheio,
    input  logic            vazio,
    input  logic            secar,
    input  logic [NE_W-1:0] n_enxague,
    output logic            bomba_agua,
    output logic            valvula_dreno,
    output logic            modo_agitar,
    output logic            modo_girar,
    output logic            modo_centrifugar,
    output logic [EST_W-1:0] estado,
    output logic            fim,
    output logic            erro
);

    estado_t         estado_q;
    estado_t         prox_c;
    logic [NE_W-1:0] rc;
    logic            lav;
    logic            sec_q;
    logic            pausa_q;
    logic            parado_c;
    logic            limpar_c;
    logic            terminal_c;
    logic            dreno_ok_c;
    logic [TW-1:0]   limite_c;

    assign parado_c   = pausa_q && em_fase(estado_q);
    assign dreno_ok_c = (estado_q == ESVAZIAR) && !parado_c && vazio;

    // Duration of the current phase; fill and drain use the timeout.
    always_comb begin
        limite_c = TW'(T_LIMITE);
        case (estado_q)
            AGITAR:      limite_c = TW'(T_AGITAR);
            MOLHO:       limite_c = TW'(T_MOLHO);
            CENTRIFUGAR: limite_c = TW'(T_CENTRIFUGAR);
            default:     ;
        endcase
    end

    // Next-state selection; sensors take precedence over the timeout.
    always_comb begin
        prox_c = estado_q;
        case (estado_q)
            ESPERA:      if (inicio) prox_c = ENCHER;
            ENCHER: begin
                if (!parado_c) begin
                    if (cheio)           prox_c = AGITAR;
                    else if (terminal_c) prox_c = ERRO;
                end
            end
            AGITAR:      if (!parado_c && terminal_c) prox_c = lav ? ESVAZIAR : MOLHO;
            MOLHO:       if (!parado_c && terminal_c) prox_c = ESVAZIAR;
            ESVAZIAR: begin
                if (dreno_ok_c) begin
                    if (rc != '0)  prox_c = ENCHER;
                    else if (sec_q) prox_c = CENTRIFUGAR;
                    else            prox_c = ESPERA;
                end else if (!parado_c && terminal_c) begin
                    prox_c = ERRO;
                end
            end
            CENTRIFUGAR: if (!parado_c && terminal_c) prox_c = ESPERA;
            ERRO:        if (inicio) prox_c = ESPERA;
            default:     prox_c = ERRO;
        endcase
    end

    // Timer restarts on every state entry and idles outside the phases.
    assign limpar_c = (prox_c != estado_q) || !em_fase(estado_q);

    temporizador_fase #(
        .TW(TW)
    ) u_temporizador (
        .clock      (clock),
        .reset_n    (reset_n),
        .limpar     (limpar_c),
        .habilitar  (!parado_c),
        .limite     (limite_c),
        .terminal_c (terminal_c)
    );

    // Outputs are decoded from the next state and the incoming pause level so
    // they line up with the registered state and pausa_q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q         <= ESPERA;
            pausa_q          <= 1'b0;
            rc               <= '0;
            lav              <= 1'b0;
            sec_q            <= 1'b0;
            bomba_agua       <= 1'b0;
            valvula_dreno    <= 1'b0;
            modo_agitar      <= 1'b0;
            modo_girar       <= 1'b0;
            modo_centrifugar <= 1'b0;
            fim              <= 1'b0;
            erro             <= 1'b0;
        end else begin
            estado_q         <= prox_c;
            pausa_q          <= pausa;
            bomba_agua       <= !pausa && (prox_c == ENCHER);
            valvula_dreno    <= !pausa && (prox_c == ESVAZIAR);
            modo_agitar      <= !pausa && (prox_c == AGITAR);
            modo_girar       <= !pausa && (prox_c == MOLHO);
            modo_centrifugar <= !pausa && (prox_c == CENTRIFUGAR);
            erro             <= (prox_c == ERRO);
            fim              <= (prox_c == ESPERA) &&
                                ((estado_q == ESVAZIAR) || (estado_q == CENTRIFUGAR));
            if ((estado_q == ESPERA) && inicio) begin
                rc    <= n_enxague;
                sec_q <= secar;
                lav   <= 1'b0;
            end
            if (dreno_ok_c) begin
                lav <= 1'b1;
                if (rc != '0) rc <= rc - NE_W'(1);
            end
        end
    end

    assign estado = estado_q;

endmodule
